// File: rtl/datapath_pipe2.sv
// Two-stage (IF | EX) RV32I datapath with EX-resolved redirects and stallable data memory.
// Optional performance counters (RetireCnt, StallCnt) when DATAPATH_PERF_EN is defined.
module datapath_pipe2 #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [1:0]  ResultSrc,
    input  logic        PCSrc,
    input  logic        ALUSrc,
    input  logic        RegWrite,
    input  logic [1:0]  ImmSrc,
    input  logic [3:0]  ALUControl,
    input  logic        Jalr,
    input  logic        MemAccess,
    output logic        Zero,
    output logic        ALUR31,
    output logic        Overflow,
    output logic [31:0] PC,
    input  logic [31:0] InstrF,
    output logic [31:0] InstrE,
    output logic        Mem_Req,
    input  logic        Mem_Ready,
    output logic [31:0] Mem_WrAddr,
    output logic [31:0] Mem_WrData,
    input  logic [31:0] ReadData,
    output logic [31:0] Result
`ifdef DATAPATH_PERF_EN
    ,
    output logic [31:0] RetireCnt,
    output logic [31:0] StallCnt
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pce_q, pce_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] rf_q [32];

    logic        hold, redirect, reg_we;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm_ext, src_b, alu_res;
    logic [31:0] pc_next, pc_target, ui_imm, ui_res;

    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];
    assign rd  = instr_q[11:7];

    assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    // Immediate extraction for the EX instruction
    always_comb begin
        imm_ext = {{20{instr_q[31]}}, instr_q[31:20]};
        case (ImmSrc)
            2'b00: imm_ext = {{20{instr_q[31]}}, instr_q[31:20]};
            2'b01: imm_ext = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            2'b10: imm_ext = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25],
                              instr_q[11:8], 1'b0};
            default: imm_ext = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20],
                                instr_q[30:21], 1'b0};
        endcase
    end

    assign src_b = ALUSrc ? imm_ext : rd2;

    // ALU and its flags
    always_comb begin
        alu_res  = rd1 + src_b;
        Overflow = 1'b0;
        case (ALUControl)
            4'd0: begin
                alu_res  = rd1 + src_b;
                Overflow = (rd1[31] == src_b[31]) & (alu_res[31] != rd1[31]);
            end
            4'd1: begin
                alu_res  = rd1 - src_b;
                Overflow = (rd1[31] != src_b[31]) & (alu_res[31] != rd1[31]);
            end
            4'd2: alu_res = rd1 & src_b;
            4'd3: alu_res = rd1 | src_b;
            4'd4: alu_res = rd1 ^ src_b;
            4'd5: alu_res = {31'd0, $signed(rd1) < $signed(src_b)};
            4'd6: alu_res = {31'd0, rd1 < src_b};
            4'd7: alu_res = rd1 << src_b[4:0];
            4'd8: alu_res = rd1 >> src_b[4:0];
            4'd9: alu_res = $unsigned($signed(rd1) >>> src_b[4:0]);
            default: alu_res = rd1 + src_b;
        endcase
    end

    assign Zero   = (alu_res == 32'd0);
    assign ALUR31 = alu_res[31];

    assign ui_imm    = {instr_q[31:12], 12'd0};
    assign ui_res    = instr_q[5] ? ui_imm : (pce_q + ui_imm);
    assign pc_target = pce_q + imm_ext;

    // Writeback select
    always_comb begin
        Result = alu_res;
        case (ResultSrc)
            2'b00: Result = alu_res;
            2'b01: Result = ReadData;
            2'b10: Result = pce_q + 32'd4;
            default: Result = ui_res;
        endcase
    end

    assign Mem_Req    = valid_q & MemAccess & ~Stall;
    assign Mem_WrAddr = alu_res;
    assign Mem_WrData = rd2;

    assign hold     = Stall | (Mem_Req & ~Mem_Ready);
    assign redirect = valid_q & (PCSrc | Jalr);
    assign reg_we   = valid_q & RegWrite & ~hold & (rd != 5'd0);

    // Next fetch address: jalr over branch/jal over sequential
    always_comb begin
        pc_next = pc_q + 32'd4;
        if (valid_q & Jalr)
            pc_next = {alu_res[31:1], 1'b0};
        else if (valid_q & PCSrc)
            pc_next = pc_target;
    end

    // IF/EX advance, hold or flush
    always_comb begin
        pc_d    = pc_q;
        pce_d   = pce_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (!hold) begin
            pc_d  = pc_next;
            pce_d = pc_q;
            if (redirect) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                instr_d = InstrF;
                valid_d = 1'b1;
            end
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            pce_q   <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pce_q   <= pce_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Register file write port (x0 never written)
    always_ff @(posedge clk) begin
        if (reg_we)
            rf_q[rd] <= Result;
    end

    assign PC     = pc_q;
    assign InstrE = instr_q;

`ifdef DATAPATH_PERF_EN
    logic [31:0] retire_q, stall_q;

    // Retired-instruction and stalled-cycle counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= 32'd0;
            stall_q  <= 32'd0;
        end else begin
            if (valid_q & ~hold)
                retire_q <= retire_q + 32'd1;
            if (valid_q & hold)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign RetireCnt = retire_q;
    assign StallCnt  = stall_q;
`endif

endmodule

// File: tb/tb_datapath_pipe2.sv
// Scoreboard bench for datapath_pipe2: a fixed program with expected PC
// sequence and writeback records queued up front, checked by a negedge monitor.
module tb_datapath_pipe2;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic [1:0]  ResultSrc;
    logic        PCSrc, ALUSrc, RegWrite, Jalr, MemAccess;
    logic [1:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        Zero, ALUR31, Overflow;
    logic [31:0] PC, InstrF, InstrE;
    logic        Mem_Req, Mem_Ready;
    logic [31:0] Mem_WrAddr, Mem_WrData, ReadData, Result;
`ifdef DATAPATH_PERF_EN
    logic [31:0] RetireCnt, StallCnt;
`endif

    datapath_pipe2 dut (
        .clk(clk), .reset(reset), .Stall(Stall), .ResultSrc(ResultSrc),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Jalr(Jalr), .MemAccess(MemAccess),
        .Zero(Zero), .ALUR31(ALUR31), .Overflow(Overflow), .PC(PC),
        .InstrF(InstrF), .InstrE(InstrE), .Mem_Req(Mem_Req),
        .Mem_Ready(Mem_Ready), .Mem_WrAddr(Mem_WrAddr),
        .Mem_WrData(Mem_WrData), .ReadData(ReadData), .Result(Result)
`ifdef DATAPATH_PERF_EN
        , .RetireCnt(RetireCnt), .StallCnt(StallCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] v;
    } wb_t;

    wb_t         wbq[$];
    logic [31:0] pcq[$];
    logic [31:0] imem [256];
    int          checks = 0;
    int          failures = 0;
    int          wcnt = 0;
    int          waits = 0;
    int          stall_n = 0;
    logic [31:0] prev_pc = 32'hFFFF_FFFF;
    logic [31:0] beq2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_i(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000,
                imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] v);
        wb_t e;
        e.rd = rd;
        e.v  = v;
        wbq.push_back(e);
    endtask

    assign InstrF   = imem[PC[9:2]];
    assign ReadData = Mem_Ready ? 32'hDEAD_BEEF : 32'd0;

    // Minimal controller decoding the EX instruction
    always_comb begin
        RegWrite   = 1'b0;
        ALUSrc     = 1'b0;
        ImmSrc     = 2'b00;
        ALUControl = 4'd0;
        ResultSrc  = 2'b00;
        PCSrc      = 1'b0;
        Jalr       = 1'b0;
        MemAccess  = 1'b0;
        case (InstrE[6:0])
            7'b0010011: begin RegWrite = 1'b1; ALUSrc = 1'b1; end
            7'b0000011: begin
                RegWrite = 1'b1; ALUSrc = 1'b1;
                MemAccess = 1'b1; ResultSrc = 2'b01;
            end
            7'b1100011: begin
                ALUControl = 4'd1; ImmSrc = 2'b10; PCSrc = Zero;
            end
            7'b1100111: begin
                RegWrite = 1'b1; ALUSrc = 1'b1;
                Jalr = 1'b1; ResultSrc = 2'b10;
            end
            7'b0110111, 7'b0010111: begin
                RegWrite = 1'b1; ResultSrc = 2'b11;
            end
            default: ;
        endcase
    end

    // Memory/stall drivers, then the monitor
    always @(negedge clk) begin
        if (reset) begin
            Mem_Ready = 1'b0;
            wcnt = 0;
            Stall = 1'b0;
        end else begin
            if (Mem_Req) begin
                if (wcnt == 3) begin
                    Mem_Ready = 1'b1;
                    wcnt = 0;
                end else begin
                    Mem_Ready = 1'b0;
                    wcnt++;
                end
            end else begin
                Mem_Ready = 1'b0;
                wcnt = 0;
            end
            if (InstrE == beq2 && stall_n < 2) begin
                Stall = 1'b1;
                stall_n++;
            end else begin
                Stall = 1'b0;
            end
            #1;
            if (PC != prev_pc) begin
                if (pcq.size() > 0)
                    chk("pc_seq", PC, pcq.pop_front());
                prev_pc = PC;
            end
            if (RegWrite && InstrE[11:7] != 5'd0 && !Stall
                && !(Mem_Req && !Mem_Ready)) begin
                if (wbq.size() == 0) begin
                    chk("wb_unexpected_rd", {27'd0, InstrE[11:7]}, 32'd0);
                end else begin
                    wb_t e;
                    e = wbq.pop_front();
                    chk("wb_rd", {27'd0, InstrE[11:7]}, {27'd0, e.rd});
                    chk("wb_val", Result, e.v);
                    if (e.rd == 5'd11)
                        chk("alur31_neg", {31'd0, ALUR31}, 32'd1);
                end
            end
            if (Mem_Req) begin
                chk("mem_addr", Mem_WrAddr, 32'h0000_0108);
                if (!Mem_Ready) begin
                    waits++;
                    chk("pc_hold_mem", PC, 32'h0000_0106);
                end
            end
            if (Stall)
                chk("pc_hold_stall", PC, 32'h0000_0116);
        end
    end

    initial begin
        beq2 = enc_b(13'h008);
        for (int i = 0; i < 256; i++)
            imem[i] = NOP;
        imem[8'h00] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem[8'h01] = enc_i(12'd3, 5'd1, 3'b000, 5'd2, 7'b0010011);
        imem[8'h02] = enc_i(12'h100, 5'd0, 3'b000, 5'd5, 7'b0010011);
        imem[8'h03] = enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'b0010011);
        imem[8'h04] = enc_b(13'h020);
        imem[8'h05] = enc_i(12'd7, 5'd0, 3'b000, 5'd4, 7'b0010011);
        imem[8'h0C] = enc_i(12'd3, 5'd5, 3'b000, 5'd1, 7'b1100111);
        imem[8'h40] = enc_i(12'd8, 5'd5, 3'b010, 5'd6, 7'b0000011);
        imem[8'h41] = enc_i(12'd1, 5'd6, 3'b000, 5'd7, 7'b0010011);
        imem[8'h42] = 32'h1234_5437;
        imem[8'h43] = 32'h0000_1497;
        imem[8'h44] = beq2;
        imem[8'h45] = enc_i(12'd9, 5'd0, 3'b000, 5'd10, 7'b0010011);
        imem[8'h46] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd11, 7'b0010011);

        pcq = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014,
                32'h030, 32'h034, 32'h102, 32'h106, 32'h10A, 32'h10E,
                32'h112, 32'h116, 32'h11A, 32'h11E, 32'h122};
        push_wb(5'd1, 32'd5);
        push_wb(5'd2, 32'd8);
        push_wb(5'd5, 32'h100);
        push_wb(5'd3, 32'd1);
        push_wb(5'd1, 32'h34);
        push_wb(5'd6, 32'hDEAD_BEEF);
        push_wb(5'd7, 32'hDEAD_BEF0);
        push_wb(5'd8, 32'h1234_5000);
        push_wb(5'd9, 32'h0000_110E);
        push_wb(5'd11, 32'hFFFF_FFFF);

        reset = 1'b1;
        Stall = 1'b0;
        Mem_Ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_pc", PC, 32'd0);
        chk("reset_instrE", InstrE, NOP);
        chk("reset_memreq", {31'd0, Mem_Req}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 300 && pcq.size() > 0; i++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        #3;
        chk("pc_queue_left", pcq.size(), 32'd0);
        chk("wb_queue_left", wbq.size(), 32'd0);
        chk("mem_wait_cycles", waits, 32'd3);
`ifdef DATAPATH_PERF_EN
        chk("stall_cnt", StallCnt, 32'd5);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
